// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: datapath width, ALU op codes,
// forwarding-select codes and the EX control-bit bundle.
package id_ex_stage_pkg;

  localparam int INSTRUCTION_SIZE = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Forwarding source select for one register operand. MEM is the younger
// producer and wins over WB; x0 is never forwarded.
module fwd_sel
  import id_ex_stage_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
  assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs);

  always_comb begin
    sel = FWD_REG;
    if (wb_hit)  sel = FWD_WB;
    if (mem_hit) sel = FWD_MEM;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding into the ALU
// and load-use hazard detection that inserts a single bubble.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = INSTRUCTION_SIZE,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_control,
  input  logic            id_src_a_pc,
  input  logic            id_src_b_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            hazard_o,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg
);

  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic            ex_src_a_pc;
  logic            ex_src_b_imm;
  ex_ctrl_t        ex_ctrl;

  logic [1:0][RA_W-1:0] src_rs;
  logic [1:0][XLEN-1:0] src_reg;
  logic [1:0][XLEN-1:0] fwd_data;
  logic [1:0][1:0]      sel;
  logic                 bubble;

  assign src_rs  = {ex_rs2, ex_rs1};
  assign src_reg = {ex_rs2_data, ex_rs1_data};

  // Index 0 is rs1, index 1 is rs2.
  for (genvar i = 0; i < 2; i++) begin : g_src
    fwd_sel #(.RA_W(RA_W)) u_fwd_sel (
      .rs            (src_rs[i]),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .sel           (sel[i])
    );
    assign fwd_data[i] = (sel[i] == FWD_MEM) ? mem_result :
                         (sel[i] == FWD_WB)  ? wb_result  : src_reg[i];
  end

  assign hazard_o = !rst && ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // A hazard only bubbles when the stage is free to advance; stall holds instead.
  assign bubble = rst || flush_i || (!stall_i && hazard_o);

  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_alu_control <= ALU_ADD;
      ex_src_a_pc    <= 1'b0;
      ex_src_b_imm   <= 1'b0;
      ex_ctrl        <= '0;
    end else if (stall_i) begin
      // Latch forwarded values so a producer leaving WB mid-stall is not lost.
      ex_rs1_data <= fwd_data[0];
      ex_rs2_data <= fwd_data[1];
    end else begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_rs1_data    <= id_rs1_data;
      ex_rs2_data    <= id_rs2_data;
      ex_imm         <= id_imm;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_alu_control <= id_alu_control;
      ex_src_a_pc    <= id_src_a_pc;
      ex_src_b_imm   <= id_src_b_imm;
      ex_ctrl        <= '{reg_write: id_reg_write, mem_read: id_mem_read,
                          mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
    end
  end

  assign ex_alu_a      = ex_src_a_pc  ? ex_pc  : fwd_data[0];
  assign ex_alu_b      = ex_src_b_imm ? ex_imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: forwarding vector table, directed hazard/stall/flush
// sequences, then random traffic against a cycle-level behavioural model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_control;
  logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard_o, ex_valid;
  logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard_o(hazard_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall_i = 0; flush_i = 0; id_valid = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 0;
    id_src_a_pc = 0; id_src_b_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  // Behavioural model: the instruction EX should currently hold.
  typedef struct {
    bit        v;
    bit [31:0] pc, d1, d2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  alu;
    bit        sa, sb, rw, mr, mw, mtr;
  } mex_t;

  mex_t m;

  function automatic mex_t empty_ex();
    mex_t e;
    e = '{default: 0};
    e.alu = ALU_ADD;
    return e;
  endfunction

  // Newest in-flight writer of a register wins; x0 always reads the regfile.
  function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] regval);
    if (r == 0) return regval;
    if (mem_reg_write && mem_rd == r) return mem_result;
    if (wb_reg_write && wb_rd == r) return wb_result;
    return regval;
  endfunction

  function automatic bit load_use();
    return !rst && m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic check_model();
    chk("valid",     32'(ex_valid),       32'(m.v));
    chk("pc",        ex_pc,               m.pc);
    chk("alu_a",     ex_alu_a,            m.sa ? m.pc : operand(m.rs1, m.d1));
    chk("alu_b",     ex_alu_b,            m.sb ? m.imm : operand(m.rs2, m.d2));
    chk("store",     ex_store_data,       operand(m.rs2, m.d2));
    chk("alu_ctl",   32'(ex_alu_control), 32'(m.alu));
    chk("rd",        32'(ex_rd),          32'(m.rd));
    chk("reg_write", 32'(ex_reg_write),   32'(m.rw));
    chk("mem_read",  32'(ex_mem_read),    32'(m.mr));
    chk("mem_write", 32'(ex_mem_write),   32'(m.mw));
    chk("mem2reg",   32'(ex_mem_to_reg),  32'(m.mtr));
    chk("hazard",    32'(hazard_o),       32'(load_use()));
  endtask

  task automatic model_tick();
    mex_t n;
    n = m;
    if (rst || flush_i || (!stall_i && load_use())) begin
      n = empty_ex();
    end else if (stall_i) begin
      n.d1 = operand(m.rs1, m.d1);
      n.d2 = operand(m.rs2, m.d2);
    end else begin
      n = '{v: id_valid, pc: id_pc, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm,
            rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu: id_alu_control,
            sa: id_src_a_pc, sb: id_src_b_imm, rw: id_reg_write, mr: id_mem_read,
            mw: id_mem_write, mtr: id_mem_to_reg};
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  typedef struct {
    string       nm;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm, pc;
    logic        sa, sb;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] ea, eb, esd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"mem_beats_wb", 5, 6, 32'hAAAA, 32'hBBBB, 0, 0, 0, 0,
                1, 5, 32'h11, 1, 5, 32'h22, 32'h11, 32'hBBBB, 32'hBBBB};
    vecs[1] = '{"wb_on_rs2", 4, 5, 1, 2, 0, 0, 0, 0,
                1, 9, 32'h33, 1, 5, 32'h22, 1, 32'h22, 32'h22};
    vecs[2] = '{"x0_no_fwd", 0, 0, 0, 0, 0, 0, 0, 0,
                1, 0, 32'h77, 1, 0, 32'hFFFF, 0, 0, 0};
    vecs[3] = '{"imm_pc_src", 0, 0, 0, 0, 32'hFFFFFFFC, 32'h100, 1, 1,
                0, 0, 0, 1, 0, 32'hFFFF, 32'h100, 32'hFFFFFFFC, 0};
    vecs[4] = '{"mem_no_we", 5, 7, 3, 4, 0, 0, 0, 0,
                0, 5, 32'h99, 1, 5, 32'h22, 32'h22, 4, 4};
    vecs[5] = '{"no_match", 10, 11, 32'h55, 32'h66, 0, 0, 0, 0,
                1, 12, 32'h1, 1, 13, 32'h2, 32'h55, 32'h66, 32'h66};

    idle();
    // Reset held two cycles with a live ID instruction.
    rst = 1; id_valid = 1; id_reg_write = 1; id_rd = 5; id_mem_read = 1;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_valid",   32'(ex_valid), 0);
    chk("rst_rw",      32'(ex_reg_write), 0);
    chk("rst_hazard",  32'(hazard_o), 0);
    chk("rst_rd",      32'(ex_rd), 0);
    chk("rst_alu_ctl", 32'(ex_alu_control), 32'(ALU_ADD));
    nxt();
    idle();

    // Forwarding vectors: load operands into EX, then present MEM/WB writers.
    foreach (vecs[i]) begin
      id_valid = 1; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_rs1_data = vecs[i].d1; id_rs2_data = vecs[i].d2;
      id_imm = vecs[i].imm; id_pc = vecs[i].pc;
      id_src_a_pc = vecs[i].sa; id_src_b_imm = vecs[i].sb;
      nxt();
      idle();
      mem_reg_write = vecs[i].mwe; mem_rd = vecs[i].mrd; mem_result = vecs[i].mres;
      wb_reg_write = vecs[i].wwe; wb_rd = vecs[i].wrd; wb_result = vecs[i].wres;
      @(negedge clk);
      chk({vecs[i].nm, "_a"}, ex_alu_a, vecs[i].ea);
      chk({vecs[i].nm, "_b"}, ex_alu_b, vecs[i].eb);
      chk({vecs[i].nm, "_sd"}, ex_store_data, vecs[i].esd);
      nxt();
      idle();
    end

    // Load-use: lw x7 in EX, add x8,x7,x1 in ID.
    id_valid = 1; id_rd = 7; id_rs1 = 2; id_mem_read = 1; id_reg_write = 1;
    id_mem_to_reg = 1; id_src_b_imm = 1;
    nxt();
    idle();
    id_valid = 1; id_rd = 8; id_rs1 = 7; id_rs2 = 1; id_reg_write = 1;
    id_rs2_data = 32'h5;
    @(negedge clk);
    chk("lu_hazard", 32'(hazard_o), 1);
    nxt();
    @(negedge clk);
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_hazard", 32'(hazard_o), 0);
    nxt();
    id_valid = 0;
    wb_reg_write = 1; wb_rd = 7; wb_result = 32'h1234;
    @(negedge clk);
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_rd", 32'(ex_rd), 8);
    chk("lu_add_a", ex_alu_a, 32'h1234);
    chk("lu_add_b", ex_alu_b, 32'h5);
    nxt();
    idle();

    // Stall while WB retires x3; the value must survive the stall.
    id_valid = 1; id_rs1 = 3; id_rs1_data = 0; id_rd = 9; id_reg_write = 1;
    nxt();
    idle();
    stall_i = 1; wb_reg_write = 1; wb_rd = 3; wb_result = 32'hDEAD;
    @(negedge clk);
    chk("stall_fwd_a", ex_alu_a, 32'hDEAD);
    nxt();
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    @(negedge clk);
    chk("stall_hold_a", ex_alu_a, 32'hDEAD);
    nxt();
    stall_i = 0;
    @(negedge clk);
    chk("stall_after_a", ex_alu_a, 32'hDEAD);
    chk("stall_after_valid", 32'(ex_valid), 1);
    chk("stall_after_rd", 32'(ex_rd), 9);

    // Flush together with stall: flush wins.
    id_valid = 1; id_mem_write = 1; id_rs2 = 4;
    nxt();
    idle();
    @(negedge clk);
    chk("st_loaded", 32'(ex_mem_write), 1);
    flush_i = 1; stall_i = 1;
    nxt();
    idle();
    @(negedge clk);
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_mw", 32'(ex_mem_write), 0);

    // Random traffic against the model, starting from a reset.
    rst = 1;
    nxt();
    rst = 0;
    m = empty_ex();
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 49) == 0);
      flush_i        = ($urandom_range(0, 9) == 0);
      stall_i        = ($urandom_range(0, 5) == 0);
      id_valid       = ($urandom_range(0, 3) != 0);
      id_pc          = $urandom;
      id_rs1_data    = $urandom;
      id_rs2_data    = $urandom;
      id_imm         = $urandom;
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_rd          = 5'($urandom_range(0, 7));
      id_alu_control = 4'($urandom_range(0, 15));
      id_src_a_pc    = 1'($urandom_range(0, 1));
      id_src_b_imm   = 1'($urandom_range(0, 1));
      id_reg_write   = 1'($urandom_range(0, 1));
      id_mem_read    = ($urandom_range(0, 2) == 0);
      id_mem_write   = 1'($urandom_range(0, 1));
      id_mem_to_reg  = 1'($urandom_range(0, 1));
      mem_reg_write  = 1'($urandom_range(0, 1));
      mem_rd         = 5'($urandom_range(0, 7));
      mem_result     = $urandom;
      wb_reg_write   = 1'($urandom_range(0, 1));
      wb_rd          = 5'($urandom_range(0, 7));
      wb_result      = $urandom;
      @(negedge clk);
      check_model();
      model_tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
